neuron_layer_pipe: RTL and testbench
====================================

// Module: neuron_layer_pipe
// PURPOSE
//  Fully-pipelined layer of NUM_NEURONS parallel neurons sharing one input activation vector.
//  Per neuron: dot product a.w -> bias add -> fixed-point round/saturate -> selectable activation.
//  Successor to the single-neuron ReLU block; adds channel count, Q-format scaling, leaky/identity
//  modes, saturation flags and valid/ready backpressure. Sits between layer weight buffers and the
//  next layer's input.
// PARAMETERS
//  INPUT_WIDTH  10  inputs per neuron (>=1)
//  NUM_NEURONS  4   neurons (output channels) computed in parallel
//  DATA_WIDTH   16  signed width of activations, weights, bias, outputs
//  ACC_WIDTH    48  signed accumulator width; elaboration error if < 2*DATA_WIDTH+$clog2(INPUT_WIDTH)+1
//  FRAC_BITS    0   fractional bits of the Q format (0..DATA_WIDTH-1)
//  LEAK_SHIFT   3   leaky-ReLU negative slope = 2^-LEAK_SHIFT
// PORTS
//  clk        in   1                                 rising-edge clock
//  rst_n      in   1                                 asynchronous active-low reset
//  in_valid   in   1                                 input beat valid
//  in_ready   out  1                                 layer can accept a beat this cycle
//  a_in       in   [INPUT_WIDTH] x DATA_WIDTH        signed activations (shared by all neurons)
//  w_in       in   [NUM_NEURONS][INPUT_WIDTH] x DW   signed weights
//  bias       in   [NUM_NEURONS] x DATA_WIDTH        signed bias, same Q format as a_in
//  act_mode   in   2                                 00 identity, 01 ReLU, 10 leaky ReLU, 11 = ReLU
//  out_valid  out  1                                 y_out/sat_out valid
//  out_ready  in   1                                 downstream accepts result
//  y_out      out  [NUM_NEURONS] x DATA_WIDTH        signed activated outputs
//  sat_out    out  [NUM_NEURONS]                     1 = that neuron's result was saturated
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, y_out, sat_out = 0. Mid-operation reset drops every in-flight beat.
//  - Pipeline: S0 products registered; L=$clog2(INPUT_WIDTH) registered adder-tree levels (odd leaf
//    padded with 0; L=0 when INPUT_WIDTH=1); SB sum+(bias<<<FRAC_BITS); SO round/saturate/activate.
//    Latency LAT = L+3 cycles from accepted beat to out_valid (INPUT_WIDTH=10 -> 7).
//  - act_mode is sampled with the beat and travels with it; mid-stream changes affect only new beats.
//  - Handshake: advance = ~out_valid | out_ready; in_ready = advance. Beat accepted iff in_valid&in_ready.
//    All stages (data+valid) hold when ~advance; no beat lost or duplicated; one beat/cycle when unstalled.
//    out_valid and y_out stay stable while out_valid & ~out_ready. Bubbles (valid=0) propagate normally.
//  - Arithmetic: products 2*DW sign-extended to ACC_WIDTH; no intermediate overflow by ACC_WIDTH rule.
//    Round: if FRAC_BITS>0 add 2^(FRAC_BITS-1) then arithmetic >>> FRAC_BITS (round half up).
//    Saturate to [-2^(DW-1), 2^(DW-1)-1]; sat_out=1 when clamped. Activation after saturation:
//    identity y=s; ReLU y = s<0 ? 0 : s; leaky y = s<0 ? s>>>LEAK_SHIFT : s (floor).
//  - Data registers load only on advance with stage valid; no reset needed on data paths except y_out/sat_out.
// STRUCTURE
//  - Package nn_pkg: act_mode_e enum (ACT_ID, ACT_RELU, ACT_LEAKY, ACT_RSVD), function
//    nn_latency(INPUT_WIDTH), saturate/round helper functions shared with other layer blocks.
//  - Sub-module neuron_dot_tree: one neuron's S0 multiply + L-level tree, with stall input;
//    instantiated NUM_NEURONS times via generate. Valid/mode pipeline lives once in the top.
// TESTING  (defaults unless stated; NUM_NEURONS=4, all neurons given same vectors unless stated)
//  1 a={10,2,99,-9,5,50,-105,20,83,39}, w={-10,12,89,300,2,9,56,12,7,107}, bias=0, ReLU
//    -> y=5609, sat=0, out_valid exactly 7 cycles after accept.
//  2 Same a, weights negated: ReLU -> 0; identity -> -5609; leaky -> -702; bias=100 identity -> -5509.
//  3 a=all 1000, w=all 1000, identity -> y=32767, sat=1; a=1000, w=-1000 -> y=-32768, sat=1.
//  4 FRAC_BITS=8: a0=384 (1.5), w0=512 (2.0), rest 0 -> y=768; w0=171 -> 65664/256=256.5 -> y=257.
//  5 Stream 20 beats back-to-back, out_ready toggling randomly -> all 20 results in order, values
//    match model, y_out stable while stalled, in_ready==0 whenever out_valid&~out_ready.
//  6 Assert rst_n low with 3 beats in flight -> out_valid/y_out/sat_out 0 at once; no stale beat after release.

Source files
------------

// File: rtl/neuron_layer_pipe_pkg.sv
// Shared definitions for the neuron layer blocks: activation modes, latency
// helper and the fixed-point round/saturate helpers.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_ID    = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_LEAKY = 2'b10,
    ACT_RSVD  = 2'b11
  } act_mode_e;

  // Result of a saturation: clamped value plus a flag telling whether it clamped.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Cycles from an accepted beat to out_valid for a given fan-in.
  function automatic int nn_latency(input int input_width);
    return $clog2(input_width) + 3;
  endfunction

  // Round half up, then drop frac_bits fractional bits (arithmetic shift).
  function automatic logic signed [63:0] nn_round(input logic signed [63:0] v,
                                                  input int frac_bits);
    logic signed [63:0] half;
    if (frac_bits <= 0) return v;
    half = 64'sd1 <<< (frac_bits - 1);
    return (v + half) >>> frac_bits;
  endfunction

  // Clamp to the signed range of a width-bit number.
  function automatic sat_res_t nn_saturate(input logic signed [63:0] v,
                                           input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (width - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_layer_pipe_if.sv
// Beat-level bus of the neuron layer: input vector/weights/bias with a
// valid/ready handshake on both the input and the result side.
interface neuron_layer_pipe_if #(
  parameter int INPUT_WIDTH = 10,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 16
);
  import nn_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] a_in [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0] w_in [NUM_NEURONS][INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0] bias [NUM_NEURONS];
  act_mode_e                    act_mode;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] y_out [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       sat_out;

  // Upstream/downstream side (weight buffers and next layer).
  modport master (
    output in_valid, a_in, w_in, bias, act_mode, out_ready,
    input  in_ready, out_valid, y_out, sat_out
  );

  // The layer itself.
  modport slave (
    input  in_valid, a_in, w_in, bias, act_mode, out_ready,
    output in_ready, out_valid, y_out, sat_out
  );

endinterface

// File: rtl/neuron_layer_pipe_dot_tree.sv
// One neuron's dot product: registered products followed by a registered
// binary adder tree. Leaves beyond INPUT_WIDTH are tied to zero so the tree is
// always a full power of two. Valid bits live in the parent; this block only
// gets the per-stage load enables (advance qualified by the incoming valid).
module neuron_dot_tree
  import nn_pkg::*;
#(
  parameter int  INPUT_WIDTH = 10,
  parameter int  DATA_WIDTH  = 16,
  parameter int  ACC_WIDTH   = 48,
  localparam int LVL         = $clog2(INPUT_WIDTH)
) (
  input  logic                         clk,
  input  logic                         advance,
  input  logic [LVL:0]                 stage_vld,
  input  logic signed [DATA_WIDTH-1:0] a_in [INPUT_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] w_in [INPUT_WIDTH],
  output logic signed [ACC_WIDTH-1:0]  sum
);

  localparam int POW = 1 << LVL;
  localparam int PW  = 2 * DATA_WIDTH;

  logic signed [ACC_WIDTH-1:0] leaf [POW];

  genvar gi;

  for (gi = 0; gi < INPUT_WIDTH; gi++) begin : g_prod
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_reg;
    assign prod = a_in[gi] * w_in[gi];
    // Stage 0: register the sign-extended product.
    always_ff @(posedge clk) begin
      if (advance && stage_vld[0]) prod_reg <= ACC_WIDTH'(prod);
    end
    assign leaf[gi] = prod_reg;
  end

  for (gi = INPUT_WIDTH; gi < POW; gi++) begin : g_pad
    assign leaf[gi] = '0;
  end

  if (LVL == 0) begin : g_flat
    assign sum = leaf[0];
  end else begin : g_tree
    // Heap layout: node 0 is the root, children of i are 2i+1 and 2i+2;
    // indices past the internal nodes map onto the leaves.
    logic signed [ACC_WIDTH-1:0] node [POW-1];

    for (gi = 0; gi < POW - 1; gi++) begin : g_node
      localparam int DEPTH = $clog2(gi + 2) - 1;
      localparam int LEVEL = LVL - DEPTH;
      logic signed [ACC_WIDTH-1:0] lhs;
      logic signed [ACC_WIDTH-1:0] rhs;
      logic signed [ACC_WIDTH-1:0] node_reg;

      if (2 * gi + 1 >= POW - 1) begin : g_leaf
        assign lhs = leaf[2 * gi + 1 - (POW - 1)];
        assign rhs = leaf[2 * gi + 2 - (POW - 1)];
      end else begin : g_inner
        assign lhs = node[2 * gi + 1];
        assign rhs = node[2 * gi + 2];
      end

      // Tree level LEVEL: pairwise sum, loads only with a valid beat.
      always_ff @(posedge clk) begin
        if (advance && stage_vld[LEVEL]) node_reg <= lhs + rhs;
      end
      assign node[gi] = node_reg;
    end

    assign sum = node[0];
  end

endmodule

// File: rtl/neuron_layer_pipe.sv
// Pipelined layer of NUM_NEURONS neurons sharing one activation vector:
// dot product tree -> bias add -> round/saturate -> activation, with a single
// stall signal (advance) freezing every stage while the output is blocked.
module neuron_layer_pipe
  import nn_pkg::*;
#(
  parameter int INPUT_WIDTH = 10,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int FRAC_BITS   = 0,
  parameter int LEAK_SHIFT  = 3
) (
  input logic          clk,
  input logic          rst_n,
  neuron_layer_pipe_if.slave nif
);

  localparam int LVL = $clog2(INPUT_WIDTH);

  if (ACC_WIDTH < 2 * DATA_WIDTH + LVL + 1) begin : g_bad_acc
    $error("ACC_WIDTH too small for DATA_WIDTH/INPUT_WIDTH");
  end
  if (ACC_WIDTH > 64) begin : g_bad_acc_wide
    $error("ACC_WIDTH above 64 is not handled by the rounding helpers");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS out of range");
  end

  logic                         advance;
  logic [LVL:0]                 vld_reg;
  logic [LVL:0]                 feed_vld;
  logic                         sb_vld_reg;
  logic                         out_valid_reg;

  logic signed [DATA_WIDTH-1:0] a_loc    [INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0] w_loc    [NUM_NEURONS][INPUT_WIDTH];
  logic signed [DATA_WIDTH-1:0] bias_loc [NUM_NEURONS];

  logic signed [DATA_WIDTH-1:0] bias_pipe [LVL+1][NUM_NEURONS];
  act_mode_e                    mode_pipe [LVL+1];

  logic signed [ACC_WIDTH-1:0]  tree_sum [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]  sum_reg  [NUM_NEURONS];
  act_mode_e                    sb_mode_reg;

  logic signed [DATA_WIDTH-1:0] y_next    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       sat_next;
  logic signed [DATA_WIDTH-1:0] y_out_reg [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       sat_out_reg;

  // The whole pipe moves together; it only stops when a held result is refused.
  assign advance      = ~out_valid_reg | nif.out_ready;
  assign nif.in_ready = advance;

  assign a_loc    = nif.a_in;
  assign w_loc    = nif.w_in;
  assign bias_loc = nif.bias;

  genvar gi;

  // feed_vld[k] is the valid bit arriving at stage k (stage 0 = the input beat).
  assign feed_vld[0] = nif.in_valid;
  for (gi = 1; gi <= LVL; gi++) begin : g_feed
    assign feed_vld[gi] = vld_reg[gi - 1];
  end

  // Valid bits for S0, every tree level, the bias stage and the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg       <= '0;
      sb_vld_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      vld_reg       <= feed_vld;
      sb_vld_reg    <= vld_reg[LVL];
      out_valid_reg <= sb_vld_reg;
    end
  end

  // Bias and activation mode ride alongside the tree so they stay with their beat.
  for (gi = 0; gi <= LVL; gi++) begin : g_side
    logic signed [DATA_WIDTH-1:0] bias_stg [NUM_NEURONS];
    act_mode_e                    mode_stg;

    if (gi == 0) begin : g_first
      // Capture bias/mode with the accepted beat.
      always_ff @(posedge clk) begin
        if (advance && feed_vld[0]) begin
          bias_stg <= bias_loc;
          mode_stg <= nif.act_mode;
        end
      end
    end else begin : g_next
      // Follow the beat one level down the tree.
      always_ff @(posedge clk) begin
        if (advance && feed_vld[gi]) begin
          bias_stg <= bias_pipe[gi - 1];
          mode_stg <= mode_pipe[gi - 1];
        end
      end
    end

    assign bias_pipe[gi] = bias_stg;
    assign mode_pipe[gi] = mode_stg;
  end

  for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
    neuron_dot_tree #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_tree (
      .clk       (clk),
      .advance   (advance),
      .stage_vld (feed_vld),
      .a_in      (a_loc),
      .w_in      (w_loc[gi]),
      .sum       (tree_sum[gi])
    );
  end

  // Bias stage: bias is lifted into the accumulator's Q format before adding.
  always_ff @(posedge clk) begin
    if (advance && vld_reg[LVL]) begin
      sb_mode_reg <= mode_pipe[LVL];
      for (int n = 0; n < NUM_NEURONS; n++) begin
        sum_reg[n] <= tree_sum[n] + (ACC_WIDTH'(bias_pipe[LVL][n]) <<< FRAC_BITS);
      end
    end
  end

  for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_so
    logic signed [63:0]           wide;
    logic signed [63:0]           rnd;
    sat_res_t                     res;
    logic signed [DATA_WIDTH-1:0] s;
    logic signed [DATA_WIDTH-1:0] y_act;

    // Round, clamp to the output width, then apply the beat's activation.
    always_comb begin
      wide = 64'(sum_reg[gi]);
      rnd  = nn_round(wide, FRAC_BITS);
      res  = nn_saturate(rnd, DATA_WIDTH);
      s    = res.val[DATA_WIDTH-1:0];
      case (sb_mode_reg)
        ACT_ID:    y_act = s;
        ACT_LEAKY: y_act = s[DATA_WIDTH-1] ? (s >>> LEAK_SHIFT) : s;
        default:   y_act = s[DATA_WIDTH-1] ? '0 : s;
      endcase
    end

    assign y_next[gi]   = y_act;
    assign sat_next[gi] = res.sat;
  end

  // Output registers: cleared on reset, otherwise load only with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) y_out_reg[n] <= '0;
      sat_out_reg <= '0;
    end else if (advance && sb_vld_reg) begin
      y_out_reg   <= y_next;
      sat_out_reg <= sat_next;
    end
  end

  assign nif.out_valid = out_valid_reg;
  assign nif.y_out     = y_out_reg;
  assign nif.sat_out   = sat_out_reg;

endmodule

// File: tb/tb_neuron_layer_pipe.sv
// Directed bench for neuron_layer_pipe: hand-computed single beats, a
// Q8 instance for rounding, a backpressured stream against a small model,
// and reset with beats in flight.
module tb_neuron_layer_pipe;
  import nn_pkg::*;

  localparam int IW = 10;
  localparam int NN = 4;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_layer_pipe_if #(.INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) nif ();
  neuron_layer_pipe_if #(.INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) nif8 ();

  neuron_layer_pipe #(
    .INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW),
    .ACC_WIDTH(48), .FRAC_BITS(0), .LEAK_SHIFT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nif   (nif)
  );

  neuron_layer_pipe #(
    .INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW),
    .ACC_WIDTH(48), .FRAC_BITS(8), .LEAK_SHIFT(3)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .nif   (nif8)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Directed beat (same for every neuron).
  int        a_vec [IW];
  int        w_vec [IW];
  int        bias_v;
  act_mode_e mode_v;

  // Stream beat (per-neuron weights and bias).
  int        s_a [IW];
  int        s_w [NN][IW];
  int        s_b [NN];
  act_mode_e s_m;

  int        exp_y_q [$];
  int        exp_s_q [$];

  task automatic drive_beat();
    for (int i = 0; i < IW; i++) nif.a_in[i] = DW'(a_vec[i]);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < IW; i++) nif.w_in[n][i] = DW'(w_vec[i]);
      nif.bias[n] = DW'(bias_v);
    end
    nif.act_mode = mode_v;
  endtask

  task automatic drive_stream();
    for (int i = 0; i < IW; i++) nif.a_in[i] = DW'(s_a[i]);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < IW; i++) nif.w_in[n][i] = DW'(s_w[n][i]);
      nif.bias[n] = DW'(s_b[n]);
    end
    nif.act_mode = s_m;
  endtask

  task automatic new_stream_beat();
    for (int i = 0; i < IW; i++) s_a[i] = int'($urandom_range(400)) - 200;
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < IW; i++) s_w[n][i] = int'($urandom_range(200)) - 100;
      s_b[n] = int'($urandom_range(2000)) - 1000;
    end
    s_m = act_mode_e'($urandom_range(3));
  endtask

  // Reference: exact dot product, bias, clamp to 16 bits, activation (Q0).
  function automatic void model_neuron(input int n, output int y, output int s);
    longint acc;
    acc = s_b[n];
    for (int i = 0; i < IW; i++) acc += longint'(s_a[i]) * longint'(s_w[n][i]);
    s = 0;
    if (acc > 32767) begin
      acc = 32767;
      s   = 1;
    end else if (acc < -32768) begin
      acc = -32768;
      s   = 1;
    end
    case (s_m)
      ACT_ID:    y = int'(acc);
      ACT_LEAKY: y = (acc < 0) ? int'(acc >>> 3) : int'(acc);
      default:   y = (acc < 0) ? 0 : int'(acc);
    endcase
  endfunction

  // One beat through an empty pipe with out_ready high; checks every neuron.
  task automatic run_single(input string tag, input int exp_y, input int exp_sat,
                            input bit chk_lat);
    int cnt;
    @(negedge clk);
    drive_beat();
    nif.in_valid  = 1'b1;
    nif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nif.in_valid = 1'b0;
    cnt = 1;
    while (!nif.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_val({tag, "_out_valid"}, nif.out_valid, 1);
    if (chk_lat) check_val({tag, "_latency"}, cnt, 7);
    for (int n = 0; n < NN; n++) begin
      check_val($sformatf("%s_y%0d", tag, n), nif.y_out[n], exp_y);
      check_val($sformatf("%s_sat%0d", tag, n), nif.sat_out[n], exp_sat);
    end
    $display("txn %s: y0=%0d sat0=%0d after %0d cycles", tag, nif.y_out[0], nif.sat_out[0], cnt);
    @(negedge clk);
  endtask

  // One beat through the Q8 instance: only input 0 non-zero, identity mode.
  task automatic run8(input string tag, input int a0, input int w0, input int exp_y);
    int cnt;
    @(negedge clk);
    for (int i = 0; i < IW; i++) nif8.a_in[i] = (i == 0) ? DW'(a0) : '0;
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < IW; i++) nif8.w_in[n][i] = (i == 0) ? DW'(w0) : '0;
      nif8.bias[n] = '0;
    end
    nif8.act_mode = ACT_ID;
    nif8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nif8.in_valid = 1'b0;
    cnt = 1;
    while (!nif8.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_val({tag, "_out_valid"}, nif8.out_valid, 1);
    for (int n = 0; n < NN; n++) begin
      check_val($sformatf("%s_y%0d", tag, n), nif8.y_out[n], exp_y);
      check_val($sformatf("%s_sat%0d", tag, n), nif8.sat_out[n], 0);
    end
    $display("txn %s: y0=%0d", tag, nif8.y_out[0]);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a [IW];
    int base_w [IW];
    int sent, got, cyc, stale;
    bit stalled_prev, gen_next;
    int held_y [NN];
    int ey, es;

    base_a = '{10, 2, 99, -9, 5, 50, -105, 20, 83, 39};
    base_w = '{-10, 12, 89, 300, 2, 9, 56, 12, 7, 107};

    nif.in_valid   = 1'b0;
    nif.out_ready  = 1'b1;
    nif8.in_valid  = 1'b0;
    nif8.out_ready = 1'b1;
    nif8.act_mode  = ACT_ID;
    for (int i = 0; i < IW; i++) begin
      a_vec[i]      = 0;
      w_vec[i]      = 0;
      nif8.a_in[i]  = '0;
    end
    for (int n = 0; n < NN; n++) begin
      nif8.bias[n] = '0;
      for (int i = 0; i < IW; i++) nif8.w_in[n][i] = '0;
    end
    bias_v = 0;
    mode_v = ACT_ID;
    drive_beat();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", nif.out_valid, 0);
    check_val("rst_sat", nif.sat_out, 0);
    for (int n = 0; n < NN; n++) check_val($sformatf("rst_y%0d", n), nif.y_out[n], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", nif.in_ready, 1);

    // Test 1: ReLU of a positive dot product, with latency
    a_vec  = base_a;
    w_vec  = base_w;
    bias_v = 0;
    mode_v = ACT_RELU;
    run_single("t1_relu", 5609, 0, 1'b1);

    // Test 2: negated weights under each activation
    for (int i = 0; i < IW; i++) w_vec[i] = -base_w[i];
    mode_v = ACT_RELU;  run_single("t2_relu", 0, 0, 1'b0);
    mode_v = ACT_ID;    run_single("t2_id", -5609, 0, 1'b0);
    mode_v = ACT_LEAKY; run_single("t2_leaky", -702, 0, 1'b0);
    mode_v = ACT_RSVD;  run_single("t2_rsvd", 0, 0, 1'b0);
    bias_v = 100;
    mode_v = ACT_ID;    run_single("t2_bias", -5509, 0, 1'b0);

    // Test 4: Q8 rounding on the second instance
    run8("t4_q8_exact", 384, 512, 768);
    run8("t4_q8_half", 384, 171, 257);

    // Test 5: 20 back-to-back beats with random out_ready
    nif.out_ready = 1'b0;
    sent = 0;
    got = 0;
    cyc = 0;
    stalled_prev = 1'b0;
    gen_next = 1'b1;
    while (got < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled_prev) begin
        check_val("stall_out_valid", nif.out_valid, 1);
        for (int n = 0; n < NN; n++)
          check_val($sformatf("stall_y%0d", n), nif.y_out[n], held_y[n]);
      end
      if (gen_next) begin
        new_stream_beat();
        drive_stream();
        gen_next = 1'b0;
      end
      nif.out_ready = 1'($urandom_range(1));
      nif.in_valid  = (sent < 20);
      #1;
      stalled_prev = nif.out_valid && !nif.out_ready;
      if (stalled_prev) begin
        check_val("stall_in_ready", nif.in_ready, 0);
        for (int n = 0; n < NN; n++) held_y[n] = nif.y_out[n];
      end
      if (nif.out_valid && nif.out_ready) begin
        if (exp_y_q.size() < NN) begin
          check_val("stream_unexpected_beat", exp_y_q.size(), NN);
        end else begin
          for (int n = 0; n < NN; n++) begin
            ey = exp_y_q.pop_front();
            es = exp_s_q.pop_front();
            check_val($sformatf("stream%0d_y%0d", got, n), nif.y_out[n], ey);
            check_val($sformatf("stream%0d_sat%0d", got, n), nif.sat_out[n], es);
          end
        end
        $display("txn stream %0d: y=%0d,%0d,%0d,%0d sat=%b", got, nif.y_out[0],
                 nif.y_out[1], nif.y_out[2], nif.y_out[3], nif.sat_out);
        got++;
      end
      if (nif.in_valid && nif.in_ready) begin
        for (int n = 0; n < NN; n++) begin
          model_neuron(n, ey, es);
          exp_y_q.push_back(ey);
          exp_s_q.push_back(es);
        end
        sent++;
        gen_next = 1'b1;
      end
    end
    check_val("stream_count", got, 20);
    check_val("stream_leftover", exp_y_q.size(), 0);
    @(negedge clk);
    nif.in_valid  = 1'b0;
    nif.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Test 3: saturation both ways
    for (int i = 0; i < IW; i++) begin
      a_vec[i] = 1000;
      w_vec[i] = 1000;
    end
    bias_v = 0;
    mode_v = ACT_ID;
    run_single("t3_sat_pos", 32767, 1, 1'b0);
    for (int i = 0; i < IW; i++) w_vec[i] = -1000;
    run_single("t3_sat_neg", -32768, 1, 1'b0);

    // Test 6: reset with 3 beats in flight (output still holds -32768 / sat)
    @(negedge clk);
    drive_beat();
    nif.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_out_valid", nif.out_valid, 0);
    check_val("t6_rst_sat", nif.sat_out, 0);
    for (int n = 0; n < NN; n++) check_val($sformatf("t6_rst_y%0d", n), nif.y_out[n], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (15) begin
      @(negedge clk);
      if (nif.out_valid) stale++;
    end
    check_val("t6_no_stale", stale, 0);
    $display("txn t6_reset: stale beats seen %0d", stale);

    // Pipe still works after the reset
    a_vec  = base_a;
    w_vec  = base_w;
    bias_v = 0;
    mode_v = ACT_RELU;
    run_single("t6_after", 5609, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
